// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and data ports.
// Optional statistics counters are compiled in with ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
`ifdef ARB_STATS_EN
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       starve_cnt,
`endif
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_STREAK);

  typedef enum logic {
    PRIO_DATA  = 1'b0,
    PRIO_FETCH = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [SW-1:0]         r_streak, w_streak_nxt, w_streak_inc;
  logic                  w_if_gnt, w_d_gnt;
  logic                  w_rd_push, w_rd_own;
  logic [RD_LATENCY-1:0] r_tag_v, r_tag_own;

  // Grants are held low during reset regardless of requests.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!rst) begin
      if (r_state == PRIO_DATA) begin
        if (d_req)       w_d_gnt  = 1'b1;
        else if (if_req) w_if_gnt = 1'b1;
      end else begin
        if (if_req)      w_if_gnt = 1'b1;
        else if (d_req)  w_d_gnt  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_streak_inc = (r_streak == MAX_S) ? r_streak : r_streak + SW'(1);
    if (w_if_gnt || !if_req) begin
      w_streak_nxt = '0;
      if (r_state == PRIO_FETCH) w_state_nxt = PRIO_DATA;
    end else if (w_d_gnt) begin
      if (w_streak_inc == MAX_S) begin
        w_state_nxt  = PRIO_FETCH;
        w_streak_nxt = '0;
      end else begin
        w_streak_nxt = w_streak_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= PRIO_DATA;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  assign if_gnt  = w_if_gnt;
  assign d_gnt   = w_d_gnt;
  assign m_en    = w_if_gnt | w_d_gnt;
  assign m_we    = w_d_gnt & d_we;
  assign m_addr  = w_d_gnt ? d_addr : (w_if_gnt ? if_addr : '0);
  assign m_wdata = (w_d_gnt & d_we) ? d_wdata : '0;

  // Tag pipeline tracks who owns each in-flight read; owner 1 = fetch.
  assign w_rd_push = w_if_gnt | (w_d_gnt & ~d_we);
  assign w_rd_own  = w_if_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v   <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_v[0]   <= w_rd_push;
      r_tag_own[0] <= w_rd_own;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign if_rvalid = r_tag_v[RD_LATENCY-1] &  r_tag_own[RD_LATENCY-1];
  assign d_rvalid  = r_tag_v[RD_LATENCY-1] & ~r_tag_own[RD_LATENCY-1];
  assign if_rdata  = m_rdata;
  assign d_rdata   = m_rdata;

`ifdef ARB_STATS_EN
  logic [31:0] r_conflict_cnt, r_starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= '0;
      r_starve_cnt   <= '0;
    end else begin
      if (if_req && d_req) r_conflict_cnt <= r_conflict_cnt + 32'd1;
      if (r_state == PRIO_DATA && w_state_nxt == PRIO_FETCH)
        r_starve_cnt <= r_starve_cnt + 32'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign starve_cnt   = r_starve_cnt;
`endif

endmodule
